uart_rx_param: RTL
==================

# uart_rx_param

Parametrised asynchronous serial receiver: the next-generation RX front end feeding the SDRAM control command path. It supports configurable data width, 1 or 2 stop bits and optional parity. Each bit is sampled with 3-point majority voting, and start-bit glitches are rejected. Each received character is delivered as a one-cycle `rx_valid` strobe, together with per-frame framing and parity error flags.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s; `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE`, integer division, must be ≥ 8.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `STOP_BITS`, default 1: stop bits checked per frame, 1 or 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` out `DATA_BITS`: last received character, LSB received first.
- `rx_valid` out 1: one-cycle strobe, character complete.
- `frame_err` out 1: qualified by `rx_valid`; a stop bit sampled low.
- `parity_err` out 1: qualified by `rx_valid`; parity mismatch.
- `busy` out 1: high from accepted start edge until return to IDLE.

## Operation
- **Synchroniser**
  - Two flops resynchronise `rx`; both reset to 1, giving `rx_s`.
  - An edge register `rx_q` follows `rx_s` and resets to 0, so a line held low at reset release is not taken as a start. The line must go high, then fall.
- **Bit-time counter**
  - `tick` runs 0..`CLKS_PER_BIT-1`, then wraps and increments `bit_idx`.
  - `HALF = CLKS_PER_BIT/2`, integer division.
  - Majority vote over `rx_s` at `tick` = `HALF-1`, `HALF`, `HALF+1`. The result is registered at `tick == HALF+1` as the bit value.
- **FSM states: IDLE, START, DATA, PARITY, STOP**
  - IDLE: `rx_q==1 && rx_s==0` → START; `tick` cleared, `busy` set.
  - START: bit value 1 → IDLE (glitch reject, no `rx_valid`). Bit value 0 → DATA at the wrap.
  - DATA: shift the bit value into `rx_data` position `bit_idx`. After `DATA_BITS` bits → PARITY if compiled in, else STOP.
  - PARITY: compare the received bit with the computed parity of the data bits; the mismatch is latched.
  - STOP: each of the `STOP_BITS` bits is voted. Any 0 latches a frame error.
  - At the vote of the final stop bit, the FSM enters IDLE immediately, without waiting for the bit end. This allows resync on a start edge half a bit later.
- **Outputs**
  - `rx_data` is written only when a frame completes and holds between frames.
  - A break (line low for the whole frame) gives `rx_valid=1`, `frame_err=1`, `rx_data=0`.
- **Reset**
  - Reset is permitted at any point, including mid-frame.
  - It aborts the frame with no strobe; the FSM goes to IDLE and all outputs go to 0.

## Timing
- Reset values: `rx_data=0`, `rx_valid=0`, `frame_err=0`, `parity_err=0`, `busy=0`.
- Start edge on `rx`: detected 3 `clk` cycles after the pin falls (2 sync stages plus the edge register).
- `rx_valid`, `frame_err` and `parity_err` pulse high for exactly one cycle, in the cycle after the final stop-bit vote is registered.
- `busy` falls in the same cycle that `rx_valid` rises.
- Error flags are 0 whenever `rx_valid` is 0.
- No backpressure: an unread `rx_data` is overwritten by the next frame.
- Baud tolerance: ±3 % with `CLKS_PER_BIT` ≥ 16.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - The PARITY state exists.
  - The frame is start + `DATA_BITS` + parity + `STOP_BITS`.
  - `parity_err` is driven as specified, using `PARITY_ODD`.
- Undefined:
  - No PARITY state; the frame is start + `DATA_BITS` + `STOP_BITS`.
  - `parity_err` is tied to 0 and `PARITY_ODD` is ignored.
  - Port list unchanged.

## Test plan
- **Basic frame:** `CLK_FREQ_HZ`=1_600_000, `BAUD_RATE`=100_000 (16 clk/bit), 8N1, send 0xA5 → one `rx_valid` pulse, `rx_data`=0xA5, both errors 0, `busy` low afterwards.
- **Glitch reject:** 5-cycle low pulse on idle `rx` → no `rx_valid`; `busy` rises then returns low; `rx_data` unchanged.
- **Framing error and break:** send 0x3C with stop bit forced low → `rx_valid` with `frame_err`=1, `rx_data`=0x3C. Then hold the line low for 12 bit times → `rx_valid`, `frame_err`=1, `rx_data`=0x00.
- **Parity (macro defined), even parity, 8E1:**
  - 0x07 with parity bit 1 → `parity_err`=0.
  - 0x07 with parity bit 0 → `parity_err`=1.
  - `PARITY_ODD`=1, 0x07 with parity bit 0 → `parity_err`=0.
- **Width and stop variants:** `DATA_BITS`=5, `STOP_BITS`=2, back-to-back 0x15, 0x0A with no idle gap → two strobes with correct data. A second stop bit low → `frame_err`=1.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF → all outputs 0 immediately. After release, the next 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-point majority vote, glitch-rejecting start.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even) and drive parity_err.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned TICK_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD > 1) begin : g_param_err
        $error("uart_rx_param: illegal parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e               state;
    logic                 rx_meta, rx_s, rx_q;
    logic [TICK_W-1:0]    tick;
    logic [IDX_W-1:0]     bit_idx;
    logic                 v0, v1;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_q;
    logic                 vote, at_vote, tick_wrap;

    always_comb begin
        vote      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
        at_vote   = (tick == TICK_W'(HALF + 1));
        tick_wrap = (tick == TICK_W'(CLKS_PER_BIT - 1));
    end

`ifdef UART_RX_PARITY_EN
    localparam logic ODD = logic'(PARITY_ODD != 0);
    logic perr_q;
    logic par_exp;
    always_comb par_exp = (^shreg) ^ ODD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_q       <= 1'b0;  // a line held low at reset release must rise before it can start
            state      <= StIdle;
            tick       <= '0;
            bit_idx    <= '0;
            v0         <= 1'b1;
            v1         <= 1'b1;
            shreg      <= '0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            rx_q       <= rx_s;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            if (state != StIdle) begin
                tick <= tick_wrap ? '0 : tick + TICK_W'(1);
                if (tick == TICK_W'(HALF - 1)) v0 <= rx_s;
                if (tick == TICK_W'(HALF))     v1 <= rx_s;
            end

            unique case (state)
                StIdle: begin
                    if (rx_q && !rx_s) begin
                        state   <= StStart;
                        tick    <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_q  <= 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (at_vote && vote) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (tick_wrap) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (at_vote) shreg[bit_idx] <= vote;
                    if (tick_wrap) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= StParity;
`else
                            state   <= StStop;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (at_vote) perr_q <= (vote != par_exp);
                    if (tick_wrap) state <= StStop;
                end
`endif
                StStop: begin
                    if (at_vote) begin
                        // Finish on the last stop vote so a start half a bit later is caught.
                        if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                            state     <= StIdle;
                            busy      <= 1'b0;
                            rx_valid  <= 1'b1;
                            rx_data   <= shreg;
                            frame_err <= ferr_q | ~vote;
`ifdef UART_RX_PARITY_EN
                            parity_err <= perr_q;
`endif
                        end else if (!vote) begin
                            ferr_q <= 1'b1;
                        end
                    end else if (tick_wrap) begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
